// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared definitions for the program-counter sequencer:
//               next-PC mode encodings carried on Sel and the Sel width.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    localparam int SEL_W = 3;

    typedef logic [SEL_W-1:0] sel_t;

    // Next-PC modes; codes 5-7 are unassigned and behave as SEL_SEQ.
    localparam sel_t SEL_SEQ    = 3'd0;
    localparam sel_t SEL_BRANCH = 3'd1;
    localparam sel_t SEL_JUMP   = 3'd2;
    localparam sel_t SEL_CALL   = 3'd3;
    localparam sel_t SEL_RET    = 3'd4;

endpackage : pc_seq_pkg
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Control/status bundle between a fetch controller (master)
//               and the PC sequencer (slave).
//   Write      : advance enable (0 = stall)
//   Sel        : next-PC mode
//   Offset     : branch displacement (two's complement)
//   Target     : absolute jump/call destination
//   Result     : current PC (registered)
//   ResultPlus : Result + STEP
//   RasEmpty / RasFull    : return stack occupancy flags
//   Overflow / Underflow  : one-cycle stack event pulses
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if
    import pc_seq_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic             Write;
    sel_t             Sel;
    logic [WIDTH-1:0] Offset;
    logic [WIDTH-1:0] Target;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] ResultPlus;
    logic             RasEmpty;
    logic             RasFull;
    logic             Overflow;
    logic             Underflow;

    modport master (
        output Write, Sel, Offset, Target,
        input  Result, ResultPlus, RasEmpty, RasFull, Overflow, Underflow
    );

    modport slave (
        input  Write, Sel, Offset, Target,
        output Result, ResultPlus, RasEmpty, RasFull, Overflow, Underflow
    );

endinterface : pc_sequencer_if
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras
// Description : Circular return-address stack. A push into a full stack
//               overwrites the oldest entry; a pop from an empty stack
//               leaves everything unchanged. Both cases raise a one-cycle
//               registered pulse.
//   Clk, Reset      : clock, synchronous active-high reset
//   push, pop       : stack operations (mutually exclusive by use)
//   push_data       : address to push
//   top             : most recently pushed entry
//   empty, full     : occupancy flags decoded from the count register
//   overflow        : pulse after a push into a full stack
//   underflow       : pulse after a pop from an empty stack
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ras #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  wire logic             Clk,
    input  wire logic             Reset,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] push_data,
    output logic      [WIDTH-1:0] top,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int               c_ptr_w   = $clog2(RAS_DEPTH);
    localparam int               c_cnt_w   = $clog2(RAS_DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(RAS_DEPTH);

    logic [WIDTH-1:0]   mem_q [RAS_DEPTH];
    // ptr_q addresses the next free slot; with a full stack that slot
    // holds the oldest entry, which is exactly what an overflowing push
    // should replace.
    logic [c_ptr_w-1:0] ptr_q, ptr_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               ovf_q, unf_q;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            ptr_d = ptr_q + 1'b1;
            if (!full) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop && !empty) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= push && full;
            unf_q <= pop && empty;
        end
    end

    // Entry storage carries no reset; a cleared count makes it unreachable.
    always_ff @(posedge Clk) begin
        if (push && !Reset) begin
            mem_q[ptr_q] <= push_data;
        end
    end

    assign top       = mem_q[ptr_q - 1'b1];
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == c_cnt_full);
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule : pc_ras
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer: registered PC with sequential,
//               branch, jump, call and return modes and a return-address
//               stack. All arithmetic wraps modulo 2^WIDTH.
//   Clk, Reset : clock, synchronous active-high reset (priority over Write)
//   ctl        : pc_sequencer_if slave (Write/Sel/Offset/Target in;
//                Result/ResultPlus/RasEmpty/RasFull/Overflow/Underflow out)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int unsigned      STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
) (
    input  wire logic     Clk,
    input  wire logic     Reset,
    pc_sequencer_if.slave ctl
);

    // Power-up value so the PC is defined before the first reset.
    logic [WIDTH-1:0] result_q = RESET_VECTOR;
    logic [WIDTH-1:0] result_d;

    logic [WIDTH-1:0] w_plus;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_ras_empty;
    logic             w_push;
    logic             w_pop;

    assign w_plus = result_q + WIDTH'(STEP);
    assign w_push = ctl.Write && (ctl.Sel == SEL_CALL);
    assign w_pop  = ctl.Write && (ctl.Sel == SEL_RET);

    always_comb begin
        result_d = w_plus;
        case (ctl.Sel)
            SEL_BRANCH: result_d = result_q + ctl.Offset;
            SEL_JUMP,
            SEL_CALL:   result_d = ctl.Target;
            // A return with nothing stacked falls through as sequential.
            SEL_RET:    if (!w_ras_empty) result_d = w_ras_top;
            default:    ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            result_q <= RESET_VECTOR;
        end else if (ctl.Write) begin
            result_q <= result_d;
        end
    end

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .Clk       (Clk),
        .Reset     (Reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_plus),
        .top       (w_ras_top),
        .empty     (w_ras_empty),
        .full      (ctl.RasFull),
        .overflow  (ctl.Overflow),
        .underflow (ctl.Underflow)
    );

    assign ctl.Result     = result_q;
    assign ctl.ResultPlus = w_plus;
    assign ctl.RasEmpty   = w_ras_empty;

endmodule : pc_sequencer
`default_nettype wire
